data_mover_fifo: RTL and testbench
==================================

DATA_MOVER_FIFO -- requirements
Module: data_mover_fifo

Interface
REQ-001 Parameter DW, default 512: AXI data width in bits; legal values are 32, 64, 128, 256, 512 and 1024.
REQ-002 Parameter AW, default 64: AXI address width in bits.
REQ-003 Parameter FIFO_DEPTH, default 128: elastic buffer depth in beats; power of two; at least 4096/(DW/8).
REQ-004 Parameter MAX_OUTSTANDING, default 4: maximum write bursts awaiting B response; range 1..15.
REQ-005 The block has one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 src_address  in  64  source byte address; aligned to burst_size.
REQ-009 dst_address  in  64  destination byte address; aligned to burst_size.
REQ-010 byte_count  in  64  transfer length in bytes; multiple of DW/8.
REQ-011 burst_size  in  13  bytes per full burst; power of two from DW/8 to 4096.
REQ-012 start  in  1  one-cycle request; sampled only while idle.
REQ-013 idle  out  1  high when no transfer is in progress.
REQ-014 done  out  1  one-cycle pulse on transfer completion.
REQ-015 error  out  2  sticky status; bit0 = read error, bit1 = write error.
REQ-016 SRC_AXI_AR{ADDR,LEN,SIZE,BURST,VALID} out AW/8/3/2/1, plus ARREADY in 1: source read-address channel.
REQ-017 SRC_AXI_R{DATA,RESP,LAST,VALID} in DW/2/1/1, plus RREADY out 1: source read-data channel.
REQ-018 DST_AXI_AW{ADDR,LEN,SIZE,BURST,VALID} out AW/8/3/2/1, plus AWREADY in 1: destination write-address channel.
REQ-019 DST_AXI_W{DATA,STRB,LAST,VALID} out DW/(DW/8)/1/1, plus WREADY in 1: destination write-data channel.
REQ-020 DST_AXI_B{RESP,VALID} in 2/1, plus BREADY out 1: destination write-response channel.

Function
REQ-021 On start while idle, the block SHALL register all inputs, clear error, and enter RUN; start while busy SHALL be ignored.
REQ-022 Beat arithmetic SHALL be: BPB = burst_size/(DW/8); total beats = byte_count/(DW/8); all bursts are BPB beats except the last, which carries the remainder beats (1..BPB).
REQ-023 ARSIZE and AWSIZE SHALL equal log2(DW/8); ARBURST and AWBURST SHALL equal 1 (INCR); WSTRB SHALL be all ones; LEN SHALL equal burst beats - 1.
REQ-024 ARVALID SHALL assert only when unreserved FIFO space is at least the next burst's beats; the AR handshake SHALL reserve that space; ARADDR, ARLEN and ARVALID SHALL stay stable until ARREADY.
REQ-025 Each successive AR and AW address SHALL advance by burst_size bytes, using AW-bit wraparound arithmetic.
REQ-026 RREADY SHALL be high throughout RUN; every R beat SHALL be written into the FIFO; RLAST SHALL be ignored for framing.
REQ-027 AWVALID SHALL assert only when the FIFO holds at least the next write burst's beats and the outstanding count is below MAX_OUTSTANDING.
REQ-028 W SHALL drain FIFO beats for AW bursts in order; WVALID SHALL be high when the FIFO is non-empty and an accepted AW burst is pending; WLAST SHALL come from an internal beat counter; W may lead AW by at most 0 bursts.
REQ-029 BREADY SHALL be high while not idle; the outstanding count SHALL increment on each AW handshake and decrement on each B handshake; a simultaneous AW and B handshake SHALL leave the count unchanged.
REQ-030 Any nonzero RRESP SHALL set error[0] and any nonzero BRESP SHALL set error[1]; the transfer SHALL continue to completion regardless.
REQ-031 FSM: IDLE -> RUN on start; RUN -> DRAIN when the last W beat is accepted; DRAIN -> IDLE when outstanding reaches 0, with done high that cycle.
REQ-032 byte_count = 0 SHALL produce done on the cycle after start, with no AXI transactions.
REQ-033 idle SHALL equal (state == IDLE) & ~start.

Reset
REQ-034 Reset assertion SHALL immediately set all VALIDs, RREADY, BREADY, done and error to 0, set idle to 1, empty the FIFO and return to IDLE, including mid-transfer; in-flight AXI traffic is abandoned.

Verification
REQ-035 DW=512, byte_count=8192, burst_size=4096, zero-wait slaves -> 2 AR and 2 AW with LEN=63 and addresses +4096; 128 W beats with data matching source; one done pulse.
REQ-036 byte_count=4352, burst_size=4096 -> bursts of LEN 63 then LEN 3; WLAST on beats 64 and 68.
REQ-037 BVALID withheld, MAX_OUTSTANDING=2, 8 bursts -> AWVALID low after 2 AW handshakes until a B handshake; done only after the 8th B.
REQ-038 Destination WREADY held low -> AR issuance stops once FIFO_DEPTH beats are reserved; no R beat is lost.
REQ-039 RRESP=2 on one beat -> error=01 held until next start; all data still written; done pulses.
REQ-040 Reset asserted mid-RUN -> all VALIDs low the same cycle, idle=1; a subsequent start completes normally.

Source files
------------

// File: rtl/data_mover_fifo.sv
`default_nettype none
// ============================================================================
// data_mover_fifo : AXI read-to-write burst mover through an elastic FIFO
// Revision 1.0
// ============================================================================
module data_mover_fifo #(
  parameter int DW              = 512,
  parameter int AW              = 64,
  parameter int FIFO_DEPTH      = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       src_address,
  input  logic [63:0]       dst_address,
  input  logic [63:0]       byte_count,
  input  logic [12:0]       burst_size,
  input  logic              start,
  output logic              idle,
  output logic              done,
  output logic [1:0]        error,
  output logic [AW-1:0]     SRC_AXI_ARADDR,
  output logic [7:0]        SRC_AXI_ARLEN,
  output logic [2:0]        SRC_AXI_ARSIZE,
  output logic [1:0]        SRC_AXI_ARBURST,
  output logic              SRC_AXI_ARVALID,
  input  logic              SRC_AXI_ARREADY,
  input  logic [DW-1:0]     SRC_AXI_RDATA,
  input  logic [1:0]        SRC_AXI_RRESP,
  input  logic              SRC_AXI_RLAST,
  input  logic              SRC_AXI_RVALID,
  output logic              SRC_AXI_RREADY,
  output logic [AW-1:0]     DST_AXI_AWADDR,
  output logic [7:0]        DST_AXI_AWLEN,
  output logic [2:0]        DST_AXI_AWSIZE,
  output logic [1:0]        DST_AXI_AWBURST,
  output logic              DST_AXI_AWVALID,
  input  logic              DST_AXI_AWREADY,
  output logic [DW-1:0]     DST_AXI_WDATA,
  output logic [DW/8-1:0]   DST_AXI_WSTRB,
  output logic              DST_AXI_WLAST,
  output logic              DST_AXI_WVALID,
  input  logic              DST_AXI_WREADY,
  input  logic [1:0]        DST_AXI_BRESP,
  input  logic              DST_AXI_BVALID,
  output logic              DST_AXI_BREADY
);

  localparam int c_BYTES = DW / 8;
  localparam int c_SIZE  = $clog2(c_BYTES);
  localparam int c_PW    = $clog2(FIFO_DEPTH);
  localparam int c_CW    = (c_PW + 1 > 14) ? c_PW + 1 : 14;
  localparam logic [c_PW:0]   c_PTR_ONE = 1;
  localparam logic [c_CW-1:0] c_CNT_ONE = 1;
  localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(FIFO_DEPTH);
  localparam logic [3:0]      c_MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state, w_next;
  logic [AW-1:0]       r_araddr, r_awaddr, r_burst_bytes;
  logic [12:0]         r_bpb, r_wbeat;
  logic [63:0]         r_ar_left, r_aw_left, r_w_left;
  logic                r_arvalid, r_awvalid;
  logic [c_CW-1:0]     r_resv, r_w_alloc;
  logic [c_PW:0]       r_wptr, r_rptr;
  logic [3:0]          r_outstanding;
  logic [1:0]          r_error;
  logic [DW-1:0]       r_mem [FIFO_DEPTH];

  logic [12:0]         w_ar_beats, w_aw_beats, w_w_len;
  logic [c_PW:0]       w_fifo_diff;
  logic [c_CW-1:0]     w_fifo_cnt;
  logic                w_space_ok, w_data_ok, w_run;
  logic                w_ar_hs, w_aw_hs, w_r_hs, w_w_hs, w_b_hs;
  logic                w_wvalid, w_wlast, w_final_w, w_start_ok, w_zero, w_done;
  logic                w_unused_rlast;

  // Every burst is BPB beats except the final one, which takes what is left.
  function automatic logic [12:0] f_beats(input logic [63:0] left, input logic [12:0] bpb);
    f_beats = (left < {51'd0, bpb}) ? left[12:0] : bpb;
  endfunction

  assign w_run       = (r_state == S_RUN);
  assign w_ar_beats  = f_beats(r_ar_left, r_bpb);
  assign w_aw_beats  = f_beats(r_aw_left, r_bpb);
  assign w_w_len     = f_beats(r_w_left, r_bpb);
  assign w_fifo_diff = r_wptr - r_rptr;
  assign w_fifo_cnt  = c_CW'(w_fifo_diff);

  // Reserved space covers beats in the FIFO plus beats still in flight on R.
  assign w_space_ok  = (c_DEPTH - r_resv) >= c_CW'(w_ar_beats);
  // Only FIFO beats not yet claimed by an accepted AW burst count toward the next one.
  assign w_data_ok   = (w_fifo_cnt - r_w_alloc) >= c_CW'(w_aw_beats);

  assign w_ar_hs     = r_arvalid & SRC_AXI_ARREADY;
  assign w_aw_hs     = r_awvalid & DST_AXI_AWREADY;
  assign w_r_hs      = SRC_AXI_RVALID & w_run;
  assign w_wvalid    = w_run & (r_w_alloc != '0);
  assign w_wlast     = (r_wbeat == w_w_len - 13'd1);
  assign w_w_hs      = w_wvalid & DST_AXI_WREADY;
  assign w_b_hs      = DST_AXI_BVALID & (r_state != S_IDLE);
  assign w_final_w   = w_w_hs & w_wlast & (r_w_left == 64'(w_w_len));
  assign w_start_ok  = start & (r_state == S_IDLE);
  assign w_zero      = ((byte_count >> c_SIZE) == 64'd0);
  assign w_unused_rlast = SRC_AXI_RLAST;

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = w_zero ? S_DRAIN : S_RUN;
      S_RUN:   if (w_final_w) w_next = S_DRAIN;
      S_DRAIN: begin
        if (r_outstanding == 4'd0) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_araddr      <= '0;
      r_awaddr      <= '0;
      r_burst_bytes <= '0;
      r_bpb         <= '0;
      r_wbeat       <= '0;
      r_ar_left     <= '0;
      r_aw_left     <= '0;
      r_w_left      <= '0;
      r_arvalid     <= 1'b0;
      r_awvalid     <= 1'b0;
      r_resv        <= '0;
      r_w_alloc     <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_outstanding <= '0;
      r_error       <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_araddr      <= src_address[AW-1:0];
        r_awaddr      <= dst_address[AW-1:0];
        r_burst_bytes <= AW'(burst_size);
        r_bpb         <= burst_size >> c_SIZE;
        r_ar_left     <= byte_count >> c_SIZE;
        r_aw_left     <= byte_count >> c_SIZE;
        r_w_left      <= byte_count >> c_SIZE;
        r_wbeat       <= '0;
        r_arvalid     <= 1'b0;
        r_awvalid     <= 1'b0;
        r_resv        <= '0;
        r_w_alloc     <= '0;
        r_wptr        <= '0;
        r_rptr        <= '0;
        r_outstanding <= '0;
        r_error       <= '0;
      end else begin
        if (w_ar_hs) begin
          r_arvalid <= 1'b0;
          r_araddr  <= r_araddr + r_burst_bytes;
          r_ar_left <= r_ar_left - 64'(w_ar_beats);
        end else if (!r_arvalid && w_run && (r_ar_left != 64'd0) && w_space_ok) begin
          r_arvalid <= 1'b1;
        end

        if (w_aw_hs) begin
          r_awvalid <= 1'b0;
          r_awaddr  <= r_awaddr + r_burst_bytes;
          r_aw_left <= r_aw_left - 64'(w_aw_beats);
        end else if (!r_awvalid && w_run && (r_aw_left != 64'd0) && w_data_ok &&
                     (r_outstanding < c_MAX_OUT)) begin
          r_awvalid <= 1'b1;
        end

        r_resv    <= r_resv + (w_ar_hs ? c_CW'(w_ar_beats) : '0) - (w_w_hs ? c_CNT_ONE : '0);
        r_w_alloc <= r_w_alloc + (w_aw_hs ? c_CW'(w_aw_beats) : '0) - (w_w_hs ? c_CNT_ONE : '0);

        case ({w_aw_hs, w_b_hs})
          2'b10:   r_outstanding <= r_outstanding + 4'd1;
          2'b01:   r_outstanding <= r_outstanding - 4'd1;
          default: r_outstanding <= r_outstanding;
        endcase

        if (w_r_hs) r_wptr <= r_wptr + c_PTR_ONE;
        if (w_w_hs) begin
          r_rptr <= r_rptr + c_PTR_ONE;
          if (w_wlast) begin
            r_wbeat  <= '0;
            r_w_left <= r_w_left - 64'(w_w_len);
          end else begin
            r_wbeat  <= r_wbeat + 13'd1;
          end
        end

        if (w_r_hs && (SRC_AXI_RRESP != 2'b00)) r_error[0] <= 1'b1;
        if (w_b_hs && (DST_AXI_BRESP != 2'b00)) r_error[1] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_r_hs) r_mem[r_wptr[c_PW-1:0]] <= SRC_AXI_RDATA;
  end

  assign idle            = (r_state == S_IDLE) & ~start;
  assign done            = w_done;
  assign error           = r_error;
  assign SRC_AXI_ARADDR  = r_araddr;
  assign SRC_AXI_ARLEN   = 8'(w_ar_beats - 13'd1);
  assign SRC_AXI_ARSIZE  = 3'(c_SIZE);
  assign SRC_AXI_ARBURST = 2'b01;
  assign SRC_AXI_ARVALID = r_arvalid;
  assign SRC_AXI_RREADY  = w_run;
  assign DST_AXI_AWADDR  = r_awaddr;
  assign DST_AXI_AWLEN   = 8'(w_aw_beats - 13'd1);
  assign DST_AXI_AWSIZE  = 3'(c_SIZE);
  assign DST_AXI_AWBURST = 2'b01;
  assign DST_AXI_AWVALID = r_awvalid;
  assign DST_AXI_WDATA   = r_mem[r_rptr[c_PW-1:0]];
  assign DST_AXI_WSTRB   = '1;
  assign DST_AXI_WLAST   = w_wlast & w_wvalid;
  assign DST_AXI_WVALID  = w_wvalid;
  assign DST_AXI_BREADY  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mover_fifo.sv
`default_nettype none
// ============================================================================
// tb_data_mover_fifo : directed bench with AXI source/destination slave models
// Revision 1.0
// ============================================================================
module tb_data_mover_fifo;
  localparam int DW = 512;
  localparam int AW = 64;

  logic clk = 1'b0, reset = 1'b1;
  logic [63:0] src_address = '0, dst_address = '0, byte_count = '0;
  logic [12:0] burst_size = '0;
  logic start = 1'b0;
  logic idle, done;
  logic [1:0] error;
  logic [AW-1:0] ARADDR, AWADDR;
  logic [7:0] ARLEN, AWLEN;
  logic [2:0] ARSIZE, AWSIZE;
  logic [1:0] ARBURST, AWBURST;
  logic ARVALID, AWVALID, RREADY, WVALID, WLAST, BREADY;
  logic ARREADY = 1'b0, AWREADY = 1'b0, WREADY = 1'b0;
  logic [DW-1:0] RDATA = '0, WDATA;
  logic [DW/8-1:0] WSTRB;
  logic [1:0] RRESP = '0, BRESP = '0;
  logic RLAST = 1'b0, RVALID = 1'b0, BVALID = 1'b0;

  data_mover_fifo #(.DW(DW), .AW(AW), .FIFO_DEPTH(128), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset), .src_address(src_address), .dst_address(dst_address),
    .byte_count(byte_count), .burst_size(burst_size), .start(start),
    .idle(idle), .done(done), .error(error),
    .SRC_AXI_ARADDR(ARADDR), .SRC_AXI_ARLEN(ARLEN), .SRC_AXI_ARSIZE(ARSIZE),
    .SRC_AXI_ARBURST(ARBURST), .SRC_AXI_ARVALID(ARVALID), .SRC_AXI_ARREADY(ARREADY),
    .SRC_AXI_RDATA(RDATA), .SRC_AXI_RRESP(RRESP), .SRC_AXI_RLAST(RLAST),
    .SRC_AXI_RVALID(RVALID), .SRC_AXI_RREADY(RREADY),
    .DST_AXI_AWADDR(AWADDR), .DST_AXI_AWLEN(AWLEN), .DST_AXI_AWSIZE(AWSIZE),
    .DST_AXI_AWBURST(AWBURST), .DST_AXI_AWVALID(AWVALID), .DST_AXI_AWREADY(AWREADY),
    .DST_AXI_WDATA(WDATA), .DST_AXI_WSTRB(WSTRB), .DST_AXI_WLAST(WLAST),
    .DST_AXI_WVALID(WVALID), .DST_AXI_WREADY(WREADY),
    .DST_AXI_BRESP(BRESP), .DST_AXI_BVALID(BVALID), .DST_AXI_BREADY(BREADY)
  );

  always #5 clk = ~clk;

  // Control knobs owned by the stimulus block
  logic w_en = 1'b1, b_en = 1'b1, bresp_err = 1'b0, clr_tog = 1'b0;
  int err_idx = -1;
  logic [63:0] src_base = '0;

  // Slave/monitor state owned by the posedge monitor
  logic clr_seen = 1'b0;
  logic [63:0] rq[$];
  logic rlq[$];
  logic [63:0] ar_addr[$], ar_len[$], aw_addr[$], aw_len[$], wlast_pos[$];
  int r_beats = 0, w_cnt = 0, b_pend = 0, b_cnt = 0, done_cnt = 0, b_at_done = 0;
  int data_err = 0, attr_bad = 0, max_out = 0;

  int n_cmp = 0, n_bad = 0;

  function automatic logic [DW-1:0] pat(input logic [63:0] a);
    return {8{a ^ 64'hC0DE_0000_0000_5A5A}};
  endfunction

  function automatic logic [63:0] qv(input logic [63:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return '1;
  endfunction

  always @(posedge clk) begin
    if (clr_tog != clr_seen) begin
      rq.delete(); rlq.delete(); ar_addr.delete(); ar_len.delete();
      aw_addr.delete(); aw_len.delete(); wlast_pos.delete();
      r_beats = 0; w_cnt = 0; b_pend = 0; b_cnt = 0; done_cnt = 0; b_at_done = 0;
      data_err = 0; attr_bad = 0; max_out = 0;
      clr_seen = clr_tog;
    end else if (!reset) begin
      if (ARVALID && ARREADY) begin
        ar_addr.push_back(ARADDR);
        ar_len.push_back(64'(ARLEN));
        if (ARSIZE != 3'd6 || ARBURST != 2'b01) attr_bad++;
        for (int i = 0; i <= int'(ARLEN); i++) begin
          rq.push_back(ARADDR + 64'(i) * 64);
          rlq.push_back(i == int'(ARLEN));
        end
      end
      if (RVALID && RREADY) begin
        void'(rq.pop_front());
        void'(rlq.pop_front());
        r_beats++;
      end
      if (AWVALID && AWREADY) begin
        aw_addr.push_back(AWADDR);
        aw_len.push_back(64'(AWLEN));
        if (AWSIZE != 3'd6 || AWBURST != 2'b01) attr_bad++;
      end
      if (WVALID && WREADY) begin
        if (WDATA !== pat(src_base + 64'(w_cnt) * 64)) data_err++;
        if (WSTRB !== '1) attr_bad++;
        w_cnt++;
        if (WLAST) begin
          wlast_pos.push_back(64'(w_cnt));
          b_pend++;
        end
      end
      if (BVALID && BREADY) begin
        b_pend--;
        b_cnt++;
      end
      if (done) begin
        done_cnt++;
        b_at_done = b_cnt;
      end
      if (aw_addr.size() - b_cnt > max_out) max_out = aw_addr.size() - b_cnt;
    end
  end

  always @(negedge clk) begin
    ARREADY = 1'b1;
    AWREADY = 1'b1;
    WREADY  = w_en;
    RVALID  = (rq.size() > 0);
    RDATA   = RVALID ? pat(rq[0]) : '0;
    RLAST   = RVALID ? rlq[0] : 1'b0;
    RRESP   = (RVALID && r_beats == err_idx) ? 2'b10 : 2'b00;
    BVALID  = b_en && (b_pend > 0);
    BRESP   = (bresp_err && b_cnt == 0) ? 2'b10 : 2'b00;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    clr_tog = ~clr_tog;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go(input logic [63:0] s, input logic [63:0] d, input logic [63:0] bc,
                    input logic [12:0] bs);
    src_base    = s;
    src_address = s;
    dst_address = d;
    byte_count  = bc;
    burst_size  = bs;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", 64'(k < limit), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({idle, done, error, ARVALID, AWVALID, WVALID, RREADY, BREADY}),
        64'b1_0_00_00000);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'(idle), 64'd1);

    // Two full 4 KiB bursts
    clear_stats();
    go(64'h1000_0000, 64'h2000_0000, 64'd8192, 13'd4096);
    wait_done(2000);
    chk("t1_ar_cnt", 64'(ar_addr.size()), 64'd2);
    chk("t1_ar_addr1", qv(ar_addr, 1), 64'h1000_1000);
    chk("t1_ar_len", {qv(ar_len, 0)[31:0], qv(ar_len, 1)[31:0]}, {32'd63, 32'd63});
    chk("t1_aw_addr0", qv(aw_addr, 0), 64'h2000_0000);
    chk("t1_aw_addr1", qv(aw_addr, 1), 64'h2000_1000);
    chk("t1_aw_len", {qv(aw_len, 0)[31:0], qv(aw_len, 1)[31:0]}, {32'd63, 32'd63});
    chk("t1_w_cnt", 64'(w_cnt), 64'd128);
    chk("t1_data", 64'(data_err), 64'd0);
    chk("t1_attr", 64'(attr_bad), 64'd0);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_error", 64'(error), 64'd0);
    chk("t1_idle", 64'(idle), 64'd1);

    // Remainder burst; a start while busy must be ignored
    clear_stats();
    go(64'h3000_0000, 64'h4000_0000, 64'd4352, 13'd4096);
    repeat (5) @(negedge clk);
    byte_count = 64'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    chk("t2_ar_len", {qv(ar_len, 0)[31:0], qv(ar_len, 1)[31:0]}, {32'd63, 32'd3});
    chk("t2_aw_len", {qv(aw_len, 0)[31:0], qv(aw_len, 1)[31:0]}, {32'd63, 32'd3});
    chk("t2_wlast", {qv(wlast_pos, 0)[31:0], qv(wlast_pos, 1)[31:0]}, {32'd64, 32'd68});
    chk("t2_w_cnt", 64'(w_cnt), 64'd68);
    chk("t2_data", 64'(data_err), 64'd0);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);

    // B withheld: outstanding limit of 2, eight 256-byte bursts, first BRESP errors
    clear_stats();
    b_en = 1'b0;
    bresp_err = 1'b1;
    go(64'h5000_0000, 64'h6000_0000, 64'd2048, 13'd256);
    repeat (100) @(negedge clk);
    chk("t3_aw_blocked", 64'(aw_addr.size()), 64'd2);
    chk("t3_awvalid_low", 64'(AWVALID), 64'd0);
    chk("t3_no_done", 64'(done_cnt), 64'd0);
    chk("t3_w_two_bursts", 64'(w_cnt), 64'd8);
    b_en = 1'b1;
    wait_done(2000);
    bresp_err = 1'b0;
    chk("t3_aw_cnt", 64'(aw_addr.size()), 64'd8);
    chk("t3_aw_addr7", qv(aw_addr, 7), 64'h6000_0700);
    chk("t3_b_at_done", 64'(b_at_done), 64'd8);
    chk("t3_max_out", 64'(max_out), 64'd2);
    chk("t3_error", 64'(error), 64'd2);
    chk("t3_data", 64'({w_cnt[15:0], data_err[15:0]}), 64'({16'd32, 16'd0}));

    // WREADY held low: reservation caps AR issue at FIFO depth
    clear_stats();
    w_en = 1'b0;
    go(64'h7000_0000, 64'h8000_0000, 64'd16384, 13'd4096);
    repeat (300) @(negedge clk);
    chk("t4_ar_capped", 64'(ar_addr.size()), 64'd2);
    chk("t4_r_beats", 64'(r_beats), 64'd128);
    chk("t4_no_w", 64'(w_cnt), 64'd0);
    w_en = 1'b1;
    wait_done(3000);
    chk("t4_ar_cnt", 64'(ar_addr.size()), 64'd4);
    chk("t4_w_cnt", 64'(w_cnt), 64'd256);
    chk("t4_data", 64'(data_err), 64'd0);

    // RRESP error on beat 5
    clear_stats();
    err_idx = 5;
    go(64'h9000_0000, 64'hA000_0000, 64'd8192, 13'd4096);
    wait_done(2000);
    err_idx = -1;
    chk("t5_error", 64'(error), 64'd1);
    chk("t5_w_cnt", 64'(w_cnt), 64'd128);
    chk("t5_data", 64'(data_err), 64'd0);
    chk("t5_done_cnt", 64'(done_cnt), 64'd1);
    repeat (10) @(negedge clk);
    chk("t5_err_sticky", 64'(error), 64'd1);

    // Zero-length transfer: done on the cycle after start, error cleared
    clear_stats();
    byte_count = 64'd0;
    start = 1'b1;
    #1;
    chk("t6_idle_start", 64'(idle), 64'd0);
    @(posedge clk);
    #1;
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_err_clear", 64'(error), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_done_pulse", 64'({done, idle}), 64'b01);
    @(negedge clk);
    chk("t6_no_axi", 64'(ar_addr.size() + aw_addr.size()), 64'd0);

    // Reset mid-transfer, then a clean rerun
    clear_stats();
    go(64'h1000_0000, 64'h2000_0000, 64'd8192, 13'd4096);
    repeat (20) @(negedge clk);
    chk("t7_busy", 64'(RREADY), 64'd1);
    reset = 1'b1;
    #1;
    chk("t7_rst_outs", 64'({idle, done, error, ARVALID, AWVALID, WVALID, RREADY, BREADY}),
        64'b1_0_00_00000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_stats();
    go(64'h1000_0000, 64'h2000_0000, 64'd8192, 13'd4096);
    wait_done(2000);
    chk("t7_w_cnt", 64'(w_cnt), 64'd128);
    chk("t7_data", 64'(data_err), 64'd0);
    chk("t7_ar_cnt", 64'(ar_addr.size()), 64'd2);
    chk("t7_done_cnt", 64'(done_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
